// File: rtl/reaction_pkg.sv
// Shared types and constants for the lights-out reaction timer.
// Optional feature macro used by this slice: REACTION_BEST_TIME_EN.
package reaction_pkg;

    // Largest supported result width in BCD digits.
    localparam int unsigned MaxDigits = 6;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StCounting,
        StDone,
        StFault,
        StTout
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // All-9s pattern for the low num_digits digits; callers slice the width they need.
    function automatic logic [4*MaxDigits-1:0] all_nines(input int unsigned num_digits);
        logic [4*MaxDigits-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (i < num_digits) begin
                v[4*i +: 4] = 4'd9;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Signal bundle between the light sequencer / display path (master) and the
// reaction timer (slave). best_bcd exists only when REACTION_BEST_TIME_EN is defined.
interface reaction_timer_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      tick;
    logic                      arm;
    logic                      lights_out;
    logic                      button;
    logic                      ack;
    logic [4*NUM_DIGITS-1:0]   bcd;
    logic                      result_valid;
    logic                      jump_start;
    logic                      timeout;
    logic                      busy;
`ifdef REACTION_BEST_TIME_EN
    logic [4*NUM_DIGITS-1:0]   best_bcd;
`endif

    modport master (
`ifdef REACTION_BEST_TIME_EN
        input  best_bcd,
`endif
        output tick, arm, lights_out, button, ack,
        input  bcd, result_valid, jump_start, timeout, busy
    );

    modport slave (
`ifdef REACTION_BEST_TIME_EN
        output best_bcd,
`endif
        input  tick, arm, lights_out, button, ack,
        output bcd, result_valid, jump_start, timeout, busy
    );

endinterface

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter that saturates at all-9s instead of wrapping.
module bcd_counter
    import reaction_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    at_max
);

    localparam int unsigned W = 4 * NUM_DIGITS;
    localparam logic [4*MaxDigits-1:0] NinesAll = all_nines(NUM_DIGITS);
    localparam logic [W-1:0] Nines = NinesAll[W-1:0];

    logic [W-1:0] count_q;
    logic [W-1:0] count_inc;
    logic         carry;
    bcd_digit_t   digit;

    assign at_max = (count_q == Nines);
    assign count  = count_q;

    // Ripple a +1 through the digits; a 9 wraps to 0 and passes the carry up.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        digit     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Count register: clear wins over enable; increments stop at all-9s.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !at_max) begin
            count_q <= count_inc;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on a sequence start, counts 1 ms ticks from lights-out to
// the button press and reports a BCD result, a jump start or a timeout.
// Optional best-time tracking is enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    reaction_timer_if.slave  bus
);

    localparam int unsigned W = 4 * NUM_DIGITS;

    state_e       state_q, state_d;
    logic         button_q;
    logic         press;
    logic         cnt_clr, cnt_en, at_max;
    logic [W-1:0] count;
    logic         result_valid_q, jump_start_q, timeout_q, busy_q;

    // Rising edge only; button_q resets high so a button held through reset is not a press.
    assign press = bus.button & ~button_q;

    bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count  (count),
        .at_max (at_max)
    );

    // Next-state and counter control; press has priority over lights_out and tick.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.arm) begin
                    state_d = StArmed;
                    cnt_clr = 1'b1;
                end
            end
            StArmed: begin
                if (press) begin
                    state_d = StFault;
                end else if (bus.lights_out) begin
                    state_d = StCounting;
                end
            end
            StCounting: begin
                if (press) begin
                    state_d = StDone;
                end else if (bus.tick) begin
                    if (at_max) begin
                        state_d = StTout;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            StDone, StFault, StTout: begin
                // arm doubles as an implicit ack and wins over ack
                if (bus.arm) begin
                    state_d = StArmed;
                    cnt_clr = 1'b1;
                end else if (bus.ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, edge-detect history and registered flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            button_q       <= 1'b1;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            button_q       <= bus.button;
            result_valid_q <= (state_d == StDone);
            jump_start_q   <= (state_d == StFault);
            timeout_q      <= (state_d == StTout);
            busy_q         <= (state_d == StArmed) || (state_d == StCounting);
        end
    end

    assign bus.bcd          = count;
    assign bus.result_valid = result_valid_q;
    assign bus.jump_start   = jump_start_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;

`ifdef REACTION_BEST_TIME_EN
    localparam logic [4*MaxDigits-1:0] NinesAll = all_nines(NUM_DIGITS);
    localparam logic [W-1:0] Nines = NinesAll[W-1:0];

    logic [W-1:0] best_q;

    // Numeric a < b, deciding on the most significant differing digit.
    function automatic logic bcd_less(input logic [W-1:0] a, input logic [W-1:0] b);
        logic less;
        logic decided;
        less    = 1'b0;
        decided = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (!decided) begin
                if (a[4*i +: 4] < b[4*i +: 4]) begin
                    less    = 1'b1;
                    decided = 1'b1;
                end else if (a[4*i +: 4] > b[4*i +: 4]) begin
                    decided = 1'b1;
                end
            end
        end
        return less;
    endfunction

    // Best time updates only on the transition into DONE; the count is frozen that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= Nines;
        end else if (state_q == StCounting && press && bcd_less(count, best_q)) begin
            best_q <= count;
        end
    end

    assign bus.best_bcd = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: a stimulus table for the short cycle-by-cycle
// behaviour, then hand-written long runs (237 ms, coincidences, reset, saturation).
module tb_reaction_timer;

    localparam int unsigned ND = 4;
    localparam int unsigned W  = 4 * ND;

    // Input vector order: {rst, arm, lights_out, button, tick, ack}
    localparam logic [5:0] InNone = 6'b000000;
    localparam logic [5:0] InRst  = 6'b100000;
    localparam logic [5:0] InArm  = 6'b010000;
    localparam logic [5:0] InLo   = 6'b001000;
    localparam logic [5:0] InBtn  = 6'b000100;
    localparam logic [5:0] InTk   = 6'b000010;
    localparam logic [5:0] InAck  = 6'b000001;

    // Flag order: {result_valid, jump_start, timeout, busy}
    localparam logic [3:0] FNone = 4'b0000;
    localparam logic [3:0] FBusy = 4'b0001;
    localparam logic [3:0] FTo   = 4'b0010;
    localparam logic [3:0] FJs   = 4'b0100;
    localparam logic [3:0] FRv   = 4'b1000;

    typedef struct packed {
        logic [5:0]   in;
        logic [W-1:0] bcd;
        logic [3:0]   flg;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] bcd;
        logic [3:0]   flg;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];
    vec_t tbl[21];

    reaction_timer_if #(.NUM_DIGITS(ND)) bus ();

    reaction_timer #(
        .NUM_DIGITS (ND)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [5:0] in, input logic [W-1:0] b, input logic [3:0] f);
        vec_t v;
        v.in  = in;
        v.bcd = b;
        v.flg = f;
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        r        = '0;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    // Apply one cycle of inputs and sample 1 time unit after the rising edge.
    task automatic drive(input logic [5:0] in);
        {rst, bus.arm, bus.lights_out, bus.button, bus.tick, bus.ack} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] in,
                         input logic [W-1:0] eb, input logic [3:0] ef);
        exp_t e;
        logic [3:0] got_f;
        e.bcd = eb;
        e.flg = ef;
        sb.push_back(e);
        drive(in);
        e = sb.pop_front();
        got_f = {bus.result_valid, bus.jump_start, bus.timeout, bus.busy};
        total++;
        if (bus.bcd !== e.bcd) begin
            bad++;
            $display("FAIL %s bcd: got %h required %h", name, bus.bcd, e.bcd);
        end
        total++;
        if (got_f !== e.flg) begin
            bad++;
            $display("FAIL %s flags(rv,js,to,busy): got %b required %b", name, got_f, e.flg);
        end
    endtask

`ifdef REACTION_BEST_TIME_EN
    task automatic check_best(input string name, input logic [W-1:0] eb);
        total++;
        if (bus.best_bcd !== eb) begin
            bad++;
            $display("FAIL %s best_bcd: got %h required %h", name, bus.best_bcd, eb);
        end
    endtask

    task automatic run_ms(input string name, input int n, input logic [W-1:0] ebest);
        drive(InArm);
        drive(InLo);
        repeat (n) drive(InTk);
        check(name, InBtn, to_bcd(n), FRv);
        check_best(name, ebest);
        drive(InAck);
        drive(InNone);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        {bus.arm, bus.lights_out, bus.button, bus.tick, bus.ack} = '0;

        // Button held through reset, then released and pressed; coincident events.
        tbl[0]  = mk(InRst | InBtn, 16'h0000, FNone);
        tbl[1]  = mk(InRst | InBtn, 16'h0000, FNone);
        tbl[2]  = mk(InArm | InBtn, 16'h0000, FBusy);
        tbl[3]  = mk(InBtn,         16'h0000, FBusy);
        tbl[4]  = mk(InNone,        16'h0000, FBusy);
        tbl[5]  = mk(InBtn,         16'h0000, FJs);
        tbl[6]  = mk(InLo | InBtn,  16'h0000, FJs);
        tbl[7]  = mk(InArm,         16'h0000, FBusy);
        tbl[8]  = mk(InLo,          16'h0000, FBusy);
        tbl[9]  = mk(InTk,          16'h0001, FBusy);
        tbl[10] = mk(InTk,          16'h0002, FBusy);
        tbl[11] = mk(InBtn | InTk,  16'h0002, FRv);
        tbl[12] = mk(InBtn | InTk,  16'h0002, FRv);
        tbl[13] = mk(InAck,         16'h0002, FNone);
        tbl[14] = mk(InArm,         16'h0000, FBusy);
        tbl[15] = mk(InLo | InTk,   16'h0000, FBusy);
        tbl[16] = mk(InTk,          16'h0001, FBusy);
        tbl[17] = mk(InBtn,         16'h0001, FRv);
        tbl[18] = mk(InArm | InAck, 16'h0000, FBusy);
        tbl[19] = mk(InLo | InBtn,  16'h0000, FJs);
        tbl[20] = mk(InAck | InBtn, 16'h0000, FNone);

        for (int i = 0; i < 21; i++) begin
            check($sformatf("vec%0d", i), tbl[i].in, tbl[i].bcd, tbl[i].flg);
        end

        // 237 ms run; arm during counting must be ignored.
        check("run_arm", InArm, 16'h0000, FBusy);
        check("run_lo", InLo, 16'h0000, FBusy);
        repeat (236) drive(InTk);
        check("run_tick237", InTk, 16'h0237, FBusy);
        check("run_arm_ignored", InArm, 16'h0237, FBusy);
        check("run_press", InBtn, 16'h0237, FRv);
        check("run_ack", InAck, 16'h0237, FNone);

        // Jump start 5 cycles after arm.
        check("js_arm", InArm, 16'h0000, FBusy);
        repeat (4) drive(InNone);
        check("js_press", InBtn, 16'h0000, FJs);
        check("js_lo_ignored", InLo, 16'h0000, FJs);
        check("js_rearm", InArm, 16'h0000, FBusy);

        // Press coincident with tick at 0x0099.
        check("co_lo", InLo, 16'h0000, FBusy);
        repeat (98) drive(InTk);
        check("co_tick99", InTk, 16'h0099, FBusy);
        check("co_press_tick", InBtn | InTk, 16'h0099, FRv);
        drive(InAck);

        // Reset in the middle of a count.
        drive(InArm);
        drive(InLo);
        repeat (149) drive(InTk);
        check("mid_tick150", InTk, 16'h0150, FBusy);
        check("mid_rst", InRst, 16'h0000, FNone);
        drive(InNone);

        // Saturation and timeout.
        drive(InArm);
        drive(InLo);
        repeat (9998) drive(InTk);
        check("sat_tick9999", InTk, 16'h9999, FBusy);
        check("sat_timeout", InTk, 16'h9999, FTo);
        check("sat_hold", InTk, 16'h9999, FTo);
        check("sat_press_ignored", InBtn, 16'h9999, FTo);
        check("sat_ack", InAck, 16'h9999, FNone);
        drive(InNone);

`ifdef REACTION_BEST_TIME_EN
        check("best_rst", InRst, 16'h0000, FNone);
        check_best("best_rst", 16'h9999);
        drive(InNone);
        run_ms("best_300", 300, 16'h0300);
        drive(InArm);
        check("best_js", InBtn, 16'h0000, FJs);
        check_best("best_js", 16'h0300);
        drive(InAck);
        drive(InNone);
        run_ms("best_180", 180, 16'h0180);
        run_ms("best_250", 250, 16'h0180);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
